// File: rtl/cdb_arbiter_pkg.sv
// Shared constants for the CDB arbiter: ROB id sizing, the reserved "no result"
// id and the number of broadcast channels.
package cdb_arbiter_pkg;

    localparam int ROB_W_DEF      = 5;
    localparam int ROB_INVALID_ID = 0;
    localparam int NUM_CDB        = 2;
    localparam int VALUE_W        = 32;

endpackage

// File: rtl/cdb_arbiter_rr_pick2.sv
// Combinational round-robin picker: starting at rr_ptr, selects the first two
// set bits of full_mask as one-hot grants for cdb0 and cdb1.
module cdb_arbiter_rr_pick2
    import cdb_arbiter_pkg::*;
#(
    parameter int N  = 4,
    parameter int PW = (N > 1) ? $clog2(N) : 1
) (
    input  logic [N-1:0]  full_mask,
    input  logic [PW-1:0] rr_ptr,
    output logic [N-1:0]  gnt0,
    output logic [N-1:0]  gnt1,
    output logic          vld0,
    output logic          vld1,
    output logic [PW-1:0] idx0,
    output logic [PW-1:0] idx1
);

    always_comb begin
        int j;
        int found;
        logic [PW-1:0] j_idx;
        gnt0  = '0;
        gnt1  = '0;
        vld0  = 1'b0;
        vld1  = 1'b0;
        idx0  = '0;
        idx1  = '0;
        found = 0;
        j     = 0;
        j_idx = '0;
        for (int k = 0; k < N; k++) begin
            j = int'(rr_ptr) + k;
            if (j >= N) j = j - N;
            j_idx = PW'(j);
            if (full_mask[j_idx] && found < NUM_CDB) begin
                if (found == 0) begin
                    vld0        = 1'b1;
                    idx0        = j_idx;
                    gnt0[j_idx] = 1'b1;
                end else begin
                    vld1        = 1'b1;
                    idx1        = j_idx;
                    gnt1[j_idx] = 1'b1;
                end
                found = found + 1;
            end
        end
    end

endmodule

// File: rtl/cdb_arbiter.sv
// Common-data-bus arbiter: one holding slot per producer, up to two slots
// broadcast per cycle in round-robin order on registered cdb0/cdb1 outputs.
module cdb_arbiter
    import cdb_arbiter_pkg::*;
#(
    parameter int NUM_REQ = 4,
    parameter int ROB_W   = ROB_W_DEF
) (
    input  logic                       clk_in,
    input  logic                       rst_in,
    input  logic                       flush_in,
    input  logic [NUM_REQ-1:0]         req_valid,
    input  logic [NUM_REQ*ROB_W-1:0]   req_rob_id,
    input  logic [NUM_REQ*VALUE_W-1:0] req_value,
    output logic [NUM_REQ-1:0]         req_ready,
    output logic [ROB_W-1:0]           cdb0_rob_id,
    output logic [VALUE_W-1:0]         cdb0_value,
    output logic [ROB_W-1:0]           cdb1_rob_id,
    output logic [VALUE_W-1:0]         cdb1_value,
    output logic                       busy_out
);

    localparam int PW = $clog2(NUM_REQ);

    logic [NUM_REQ-1:0] slot_full_q, slot_full_d;
    logic [ROB_W-1:0]   slot_id_q  [NUM_REQ];
    logic [ROB_W-1:0]   slot_id_d  [NUM_REQ];
    logic [VALUE_W-1:0] slot_val_q [NUM_REQ];
    logic [VALUE_W-1:0] slot_val_d [NUM_REQ];
    logic [PW-1:0]      rr_ptr_q, rr_ptr_d;
    logic [ROB_W-1:0]   cdb0_id_q, cdb0_id_d, cdb1_id_q, cdb1_id_d;
    logic [VALUE_W-1:0] cdb0_val_q, cdb0_val_d, cdb1_val_q, cdb1_val_d;

    logic [NUM_REQ-1:0] pick_mask, gnt0, gnt1, grant, accept;
    logic               gnt_vld0, gnt_vld1;
    logic [PW-1:0]      gnt_idx0, gnt_idx1;

    // Grants never look at req_valid, so ready -> valid -> ready cannot loop.
    assign pick_mask = slot_full_q & {NUM_REQ{~flush_in}};
    assign grant     = gnt0 | gnt1;
    assign req_ready = flush_in ? '0 : (~slot_full_q | grant);
    assign busy_out  = |slot_full_q;

    cdb_arbiter_rr_pick2 #(.N(NUM_REQ), .PW(PW)) u_pick (
        .full_mask (pick_mask),
        .rr_ptr    (rr_ptr_q),
        .gnt0      (gnt0),
        .gnt1      (gnt1),
        .vld0      (gnt_vld0),
        .vld1      (gnt_vld1),
        .idx0      (gnt_idx0),
        .idx1      (gnt_idx1)
    );

    function automatic logic [PW-1:0] next_ptr(input logic [PW-1:0] idx);
        return (int'(idx) == NUM_REQ - 1) ? '0 : idx + 1'b1;
    endfunction

    always_comb begin
        slot_full_d = slot_full_q;
        slot_id_d   = slot_id_q;
        slot_val_d  = slot_val_q;
        accept      = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            accept[i] = req_valid[i] && req_ready[i] &&
                        (req_rob_id[i*ROB_W +: ROB_W] != ROB_W'(ROB_INVALID_ID));
            if (flush_in) begin
                slot_full_d[i] = 1'b0;
            end else if (accept[i]) begin
                slot_full_d[i] = 1'b1;
                slot_id_d[i]   = req_rob_id[i*ROB_W +: ROB_W];
                slot_val_d[i]  = req_value[i*VALUE_W +: VALUE_W];
            end else if (grant[i]) begin
                slot_full_d[i] = 1'b0;
            end
        end
    end

    // Idle channels report id 0 but keep their last value.
    always_comb begin
        rr_ptr_d   = rr_ptr_q;
        cdb0_id_d  = '0;
        cdb1_id_d  = '0;
        cdb0_val_d = cdb0_val_q;
        cdb1_val_d = cdb1_val_q;
        if (gnt_vld0) begin
            cdb0_id_d  = slot_id_q[gnt_idx0];
            cdb0_val_d = slot_val_q[gnt_idx0];
            rr_ptr_d   = next_ptr(gnt_idx0);
        end
        if (gnt_vld1) begin
            cdb1_id_d  = slot_id_q[gnt_idx1];
            cdb1_val_d = slot_val_q[gnt_idx1];
            rr_ptr_d   = next_ptr(gnt_idx1);
        end
    end

    always_ff @(posedge clk_in or posedge rst_in) begin
        if (rst_in) begin
            slot_full_q <= '0;
            rr_ptr_q    <= '0;
            cdb0_id_q   <= '0;
            cdb1_id_q   <= '0;
            cdb0_val_q  <= '0;
            cdb1_val_q  <= '0;
            for (int i = 0; i < NUM_REQ; i++) begin
                slot_id_q[i]  <= '0;
                slot_val_q[i] <= '0;
            end
        end else begin
            slot_full_q <= slot_full_d;
            slot_id_q   <= slot_id_d;
            slot_val_q  <= slot_val_d;
            rr_ptr_q    <= rr_ptr_d;
            cdb0_id_q   <= cdb0_id_d;
            cdb1_id_q   <= cdb1_id_d;
            cdb0_val_q  <= cdb0_val_d;
            cdb1_val_q  <= cdb1_val_d;
        end
    end

    assign cdb0_rob_id = cdb0_id_q;
    assign cdb0_value  = cdb0_val_q;
    assign cdb1_rob_id = cdb1_id_q;
    assign cdb1_value  = cdb1_val_q;

    // Two ports completing the same ROB id means an upstream decode error.
    assert property (@(posedge clk_in) disable iff (rst_in)
        (gnt_vld0 && gnt_vld1) |-> (slot_id_q[gnt_idx0] != slot_id_q[gnt_idx1]));

endmodule

// File: tb/tb_cdb_arbiter.sv
// Directed bench for cdb_arbiter: each task drives one scenario and compares
// outputs against hand-computed values.
module tb_cdb_arbiter;

    localparam int NUM_REQ = 4;
    localparam int ROB_W   = 5;

    logic                   clk_in = 1'b0;
    logic                   rst_in;
    logic                   flush_in;
    logic [NUM_REQ-1:0]     req_valid;
    logic [NUM_REQ*ROB_W-1:0] req_rob_id;
    logic [NUM_REQ*32-1:0]  req_value;
    logic [NUM_REQ-1:0]     req_ready;
    logic [ROB_W-1:0]       cdb0_rob_id, cdb1_rob_id;
    logic [31:0]            cdb0_value, cdb1_value;
    logic                   busy_out;

    int vectors     = 0;
    int miscompares = 0;

    cdb_arbiter #(.NUM_REQ(NUM_REQ), .ROB_W(ROB_W)) dut (
        .clk_in      (clk_in),
        .rst_in      (rst_in),
        .flush_in    (flush_in),
        .req_valid   (req_valid),
        .req_rob_id  (req_rob_id),
        .req_value   (req_value),
        .req_ready   (req_ready),
        .cdb0_rob_id (cdb0_rob_id),
        .cdb0_value  (cdb0_value),
        .cdb1_rob_id (cdb1_rob_id),
        .cdb1_value  (cdb1_value),
        .busy_out    (busy_out)
    );

    always #5 clk_in = ~clk_in;

    task automatic set_req(input int port, input logic [ROB_W-1:0] id, input logic [31:0] val);
        req_valid[port]               = 1'b1;
        req_rob_id[port*ROB_W +: ROB_W] = id;
        req_value[port*32 +: 32]      = val;
    endtask

    task automatic clear_reqs();
        req_valid  = '0;
        req_rob_id = '0;
        req_value  = '0;
    endtask

    task automatic after_edge();
        @(posedge clk_in);
        #1;
    endtask

    task automatic do_reset();
        @(negedge clk_in);
        rst_in = 1'b1;
        @(negedge clk_in);
        rst_in = 1'b0;
    endtask

    task automatic test_reset();
        rst_in   = 1'b1;
        flush_in = 1'b0;
        clear_reqs();
        #2;
        vectors++;
        if (cdb0_rob_id !== 5'd0 || cdb1_rob_id !== 5'd0) begin
            miscompares++;
            $display("[TB] FAIL reset_ids: got %0d/%0d expected 0/0", cdb0_rob_id, cdb1_rob_id);
        end
        vectors++;
        if (cdb0_value !== 32'd0 || cdb1_value !== 32'd0) begin
            miscompares++;
            $display("[TB] FAIL reset_values: got %h/%h expected 0/0", cdb0_value, cdb1_value);
        end
        vectors++;
        if (busy_out !== 1'b0 || req_ready !== 4'hF) begin
            miscompares++;
            $display("[TB] FAIL reset_busy_ready: got busy=%b ready=%b expected 0/1111", busy_out, req_ready);
        end
        @(negedge clk_in);
        rst_in = 1'b0;
    endtask

    task automatic test_single();
        @(negedge clk_in);
        set_req(2, 5'd5, 32'hDEADBEEF);
        after_edge();
        vectors++;
        if (busy_out !== 1'b1 || cdb0_rob_id !== 5'd0) begin
            miscompares++;
            $display("[TB] FAIL single_accept: got busy=%b cdb0=%0d expected 1/0", busy_out, cdb0_rob_id);
        end
        @(negedge clk_in);
        clear_reqs();
        after_edge();
        vectors++;
        if (cdb0_rob_id !== 5'd5 || cdb0_value !== 32'hDEADBEEF) begin
            miscompares++;
            $display("[TB] FAIL single_cdb0: got %0d/%h expected 5/deadbeef", cdb0_rob_id, cdb0_value);
        end
        vectors++;
        if (cdb1_rob_id !== 5'd0 || dut.rr_ptr_q !== 2'd3) begin
            miscompares++;
            $display("[TB] FAIL single_cdb1_rr: got cdb1=%0d rr=%0d expected 0/3", cdb1_rob_id, dut.rr_ptr_q);
        end
        after_edge();
        vectors++;
        if (cdb0_rob_id !== 5'd0 || cdb1_rob_id !== 5'd0 || cdb0_value !== 32'hDEADBEEF) begin
            miscompares++;
            $display("[TB] FAIL single_idle: got %0d/%0d val=%h expected 0/0 deadbeef",
                     cdb0_rob_id, cdb1_rob_id, cdb0_value);
        end
    endtask

    task automatic test_all_four();
        @(negedge clk_in);
        for (int p = 0; p < NUM_REQ; p++) set_req(p, 5'(p + 1), 32'(32'h100 + p));
        after_edge();
        @(negedge clk_in);
        clear_reqs();
        after_edge();
        vectors++;
        if (cdb0_rob_id !== 5'd1 || cdb1_rob_id !== 5'd2) begin
            miscompares++;
            $display("[TB] FAIL all4_first: got %0d/%0d expected 1/2", cdb0_rob_id, cdb1_rob_id);
        end
        vectors++;
        if (cdb0_value !== 32'h100 || cdb1_value !== 32'h101 || busy_out !== 1'b1) begin
            miscompares++;
            $display("[TB] FAIL all4_first_vals: got %h/%h busy=%b expected 100/101 1",
                     cdb0_value, cdb1_value, busy_out);
        end
        after_edge();
        vectors++;
        if (cdb0_rob_id !== 5'd3 || cdb1_rob_id !== 5'd4) begin
            miscompares++;
            $display("[TB] FAIL all4_second: got %0d/%0d expected 3/4", cdb0_rob_id, cdb1_rob_id);
        end
        vectors++;
        if (dut.rr_ptr_q !== 2'd0 || busy_out !== 1'b0) begin
            miscompares++;
            $display("[TB] FAIL all4_wrap: got rr=%0d busy=%b expected 0/0", dut.rr_ptr_q, busy_out);
        end
    endtask

    task automatic test_back_to_back();
        logic [ROB_W-1:0] ids [3];
        ids[0] = 5'd7;
        ids[1] = 5'd8;
        ids[2] = 5'd9;
        for (int n = 0; n < 3; n++) begin
            @(negedge clk_in);
            set_req(0, ids[n], 32'(32'hA0 + n));
            #1;
            vectors++;
            if (req_ready[0] !== 1'b1) begin
                miscompares++;
                $display("[TB] FAIL b2b_ready%0d: got %b expected 1", n, req_ready[0]);
            end
            after_edge();
            if (n > 0) begin
                vectors++;
                if (cdb0_rob_id !== ids[n-1]) begin
                    miscompares++;
                    $display("[TB] FAIL b2b_cdb0_%0d: got %0d expected %0d", n, cdb0_rob_id, ids[n-1]);
                end
            end
        end
        @(negedge clk_in);
        clear_reqs();
        after_edge();
        vectors++;
        if (cdb0_rob_id !== 5'd9 || cdb0_value !== 32'hA2) begin
            miscompares++;
            $display("[TB] FAIL b2b_last: got %0d/%h expected 9/a2", cdb0_rob_id, cdb0_value);
        end
    endtask

    task automatic test_flush();
        @(negedge clk_in);
        set_req(1, 5'd3, 32'h33);
        set_req(2, 5'd6, 32'h66);
        after_edge();
        @(negedge clk_in);
        clear_reqs();
        set_req(0, 5'd20, 32'h20);
        flush_in = 1'b1;
        #1;
        vectors++;
        if (req_ready !== 4'b0000) begin
            miscompares++;
            $display("[TB] FAIL flush_ready: got %b expected 0000", req_ready);
        end
        after_edge();
        vectors++;
        if (cdb0_rob_id !== 5'd0 || cdb1_rob_id !== 5'd0 || busy_out !== 1'b0) begin
            miscompares++;
            $display("[TB] FAIL flush_clear: got %0d/%0d busy=%b expected 0/0 0",
                     cdb0_rob_id, cdb1_rob_id, busy_out);
        end
        @(negedge clk_in);
        flush_in = 1'b0;
        clear_reqs();
        after_edge();
        vectors++;
        if (cdb0_rob_id !== 5'd0 || cdb1_rob_id !== 5'd0 || dut.rr_ptr_q !== 2'd1) begin
            miscompares++;
            $display("[TB] FAIL flush_after: got %0d/%0d rr=%0d expected 0/0 1",
                     cdb0_rob_id, cdb1_rob_id, dut.rr_ptr_q);
        end
    endtask

    task automatic test_invalid_id();
        @(negedge clk_in);
        set_req(1, 5'd0, 32'h1234);
        after_edge();
        vectors++;
        if (busy_out !== 1'b0) begin
            miscompares++;
            $display("[TB] FAIL invalid_busy: got %b expected 0", busy_out);
        end
        @(negedge clk_in);
        clear_reqs();
        after_edge();
        vectors++;
        if (cdb0_rob_id !== 5'd0 || cdb1_rob_id !== 5'd0) begin
            miscompares++;
            $display("[TB] FAIL invalid_cdb: got %0d/%0d expected 0/0", cdb0_rob_id, cdb1_rob_id);
        end
    endtask

    task automatic test_async_reset();
        @(negedge clk_in);
        set_req(0, 5'd10, 32'hAAA0);
        set_req(1, 5'd11, 32'hAAA1);
        set_req(2, 5'd13, 32'hAAA2);
        after_edge();
        @(negedge clk_in);
        clear_reqs();
        after_edge();
        vectors++;
        if (cdb0_rob_id !== 5'd11 || cdb1_rob_id !== 5'd13 || busy_out !== 1'b1) begin
            miscompares++;
            $display("[TB] FAIL async_predrain: got %0d/%0d busy=%b expected 11/13 1",
                     cdb0_rob_id, cdb1_rob_id, busy_out);
        end
        #1;
        rst_in = 1'b1;
        #1;
        vectors++;
        if (cdb0_rob_id !== 5'd0 || cdb1_rob_id !== 5'd0 || busy_out !== 1'b0) begin
            miscompares++;
            $display("[TB] FAIL async_ids: got %0d/%0d busy=%b expected 0/0 0",
                     cdb0_rob_id, cdb1_rob_id, busy_out);
        end
        vectors++;
        if (cdb0_value !== 32'd0 || cdb1_value !== 32'd0 || dut.rr_ptr_q !== 2'd0) begin
            miscompares++;
            $display("[TB] FAIL async_vals: got %h/%h rr=%0d expected 0/0 0",
                     cdb0_value, cdb1_value, dut.rr_ptr_q);
        end
        @(negedge clk_in);
        rst_in = 1'b0;
        set_req(3, 5'd12, 32'hC0C0);
        after_edge();
        @(negedge clk_in);
        clear_reqs();
        after_edge();
        vectors++;
        if (cdb0_rob_id !== 5'd12 || cdb0_value !== 32'hC0C0 || cdb1_rob_id !== 5'd0) begin
            miscompares++;
            $display("[TB] FAIL async_after: got %0d/%h cdb1=%0d expected 12/c0c0 0",
                     cdb0_rob_id, cdb0_value, cdb1_rob_id);
        end
    endtask

    initial begin
        test_reset();
        test_single();
        do_reset();
        test_all_four();
        test_back_to_back();
        test_flush();
        test_invalid_id();
        test_async_reset();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/cdb_arbiter.md
Name: cdb_arbiter

Overview:
- Shares the two common-data-bus result channels (cdb0, cdb1) among NUM_REQ functional-unit producers, e.g. two ALUs, the load unit and store completion.
- Each producer has a one-entry holding slot. Up to two full slots are granted per cycle in round-robin order.
- Granted values appear on registered CDB outputs, which feed the ROB, the reservation stations and the decoder bypass.
- A flush discards all pending results.

Parameters:
- NUM_REQ, 4, number of producer ports (2..8).
- ROB_W, 5, ROB id width. Id 0 means "no result".

Ports:
- clk_in  in  1  system clock
- rst_in  in  1  asynchronous active-high reset
- flush_in  in  1  pipeline flush (ROB flush_outputs)
- req_valid  in  NUM_REQ  producer i has a result
- req_rob_id  in  NUM_REQ*ROB_W  ROB id per producer; 0 = invalid
- req_value  in  NUM_REQ*32  result value per producer
- req_ready  out  NUM_REQ  slot i can accept this cycle
- cdb0_rob_id  out  ROB_W  channel 0 id; 0 = idle
- cdb0_value  out  32  channel 0 value
- cdb1_rob_id  out  ROB_W  channel 1 id; 0 = idle
- cdb1_value  out  32  channel 1 value
- busy_out  out  1  any slot full

Behaviour:
Reset and clocking:
- Reset (async, active-high): all slots empty, rr_ptr=0, cdb0/cdb1 rob_id=0 and value=0, busy_out=0.
- All outputs take effect at the clock edge, except req_ready.
- req_ready[i] is combinational: ready = !slot_full[i] || grant[i].
- grant depends only on slot state, rr_ptr and flush_in, never on req_valid, so there is no combinational loop.

Accept:
- Slot i loads when req_valid[i] && req_ready[i] && req_rob_id[i]!=0 && !flush_in.
- req_valid with rob_id 0 is ignored; no slot is loaded.
- A slot granted this cycle may be reloaded in the same cycle.

Arbitration (per cycle, when !flush_in):
- Scan slots i = rr_ptr, rr_ptr+1, ... modulo NUM_REQ.
- The first full slot goes to cdb0; the second full slot goes to cdb1.
- Granted slots clear at the edge.
- If slots are granted, rr_ptr <= (index of last granted slot + 1) mod NUM_REQ. Otherwise rr_ptr is unchanged.

Latency and outputs:
- Accept at edge t → earliest broadcast is registered at edge t+1 (visible in cycle t+1..t+2).
- A channel with no grant drives rob_id 0, and its value holds its last value.
- With a single full slot, only cdb0 is used.

Fairness:
- A full slot is granted within ceil(NUM_REQ/2) cycles of becoming full.
- No full slot is ever skipped in favour of a newer one.

Flush:
- flush_in=1 at an edge: all slots cleared, no accept, no grant.
- cdb0_rob_id and cdb1_rob_id go to 0; rr_ptr is unchanged.
- req_ready is forced to 0 while flush_in=1.

busy_out = OR of slot_full (registered state).

Boundaries:
- All slots full with NUM_REQ=4: drains in 2 cycles.
- rr_ptr wrap-around: NUM_REQ-1 → 0.
- Duplicate rob_id on two ports: both are broadcast; there is no dedup (a decode error upstream, flagged only by assertion).
- Reset asserted mid-operation clears everything immediately, without waiting for the clock.

Decomposition:
- Shared package (const_def.v): ROB_W / ROB_RANGE, ROB_INVALID_ID = 0, NUM_CDB = 2.
- One sub-module is natural: rr_pick2. It is combinational: it takes a full mask and rr_ptr, and outputs two one-hot grants plus their valid bits.
- The slot registers and output registers live in cdb_arbiter.

Test Plan:
- Single producer: port 2 sends id=5, value 0xDEADBEEF at edge 0 → cdb0_rob_id=5, cdb0_value=0xDEADBEEF after edge 1; cdb1_rob_id=0; rr_ptr=3; after edge 2 both ids are 0.
- All four ports valid, ids 1..4, rr_ptr=0 → edge 1: cdb0/cdb1 = ids 1/2; edge 2: ids 3/4; rr_ptr=0 after the wrap; busy_out=0 after edge 2.
- Back-to-back: port 0 streams ids 7, 8, 9 every cycle with req_valid high → req_ready stays 1 throughout; cdb0 shows 7, 8, 9 on consecutive cycles.
- Flush with slots full (ids 3, 6): flush_in=1 for one cycle → cdb ids are 0 on the next cycle, busy_out=0, req_ready=0 during the flush cycle, and neither id ever appears.
- Invalid id: port 1 req_valid=1, rob_id=0 → no slot load, busy_out stays 0, cdb ids stay 0.
- Async reset mid-drain: assert rst_in between edges with 3 slots full → all outputs 0 and busy_out=0 immediately; after release, a new id=12 on port 3 is broadcast on cdb0.
